hazard_scoreboard: RTL and testbench

//  Parametrised scoreboard-based RAW hazard detector for the ID stage of the MIPS32/SAD pipeline.
//  - Holds one countdown counter per architectural register, replacing per-stage WriteRegister

---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard RAW hazard detector for the ID stage: one countdown counter per register plus SAD buffer-ready stall.
// Optional HAZARD_STATS_EN adds the stall_cycles / buf_stall_cycles counters.

module hazard_cnt #(
    parameter int CNT_W      = 3,
    parameter int WB_LATENCY = 5
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    output logic busy
);
    logic [CNT_W-1:0] cnt;

    // Reload wins over decrement so a WAW rewrite restarts the full window
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(WB_LATENCY);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign busy = (cnt != '0);
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_AW     = 5,
    parameter int WB_LATENCY = 5,
    parameter int CNT_W      = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                id_valid,
    input  logic                id_kill,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_reg_write,
    input  logic [REG_AW-1:0]   id_write_reg,
    input  logic                id_need_buf,
    input  logic                buf_ready,
    output logic                id_stall,
    output logic                id_issue,
    output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         buf_stall_cycles
`endif
);
    localparam int IDX_SPAN = 2 ** REG_AW;

    logic [IDX_SPAN-1:0] busy_ext;
    logic                rs_haz, rt_haz, buf_haz;
    logic                wr_en;

    assign busy_vec[0] = 1'b0;
    assign wr_en       = id_issue & id_reg_write;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_reg
            hazard_cnt #(
                .CNT_W      (CNT_W),
                .WB_LATENCY (WB_LATENCY)
            ) u_cnt (
                .Clk   (Clk),
                .Reset (Reset),
                .load  (wr_en & (id_write_reg == REG_AW'(r))),
                .busy  (busy_vec[r])
            );
        end
    endgenerate

    // Indices beyond NUM_REGS land on zero-padded bits and read as free
    always_comb begin
        busy_ext               = '0;
        busy_ext[NUM_REGS-1:0] = busy_vec;
    end

    assign rs_haz  = id_use_rs & (id_rs != '0) & busy_ext[id_rs];
    assign rt_haz  = id_use_rt & (id_rt != '0) & busy_ext[id_rt];
    assign buf_haz = id_need_buf & ~buf_ready;

    assign id_stall = ~Reset & id_valid & ~id_kill & (rs_haz | rt_haz | buf_haz);
    assign id_issue = ~Reset & id_valid & ~id_kill & ~id_stall;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cycles     <= '0;
            buf_stall_cycles <= '0;
        end else begin
            if (id_stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (id_stall & buf_haz & ~rs_haz & ~rt_haz)
                buf_stall_cycles <= buf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: per-cycle expectations queued at drive time, popped by a monitor.
module tb_hazard_scoreboard;
    localparam int NREGS = 24;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             id_valid, id_kill, id_use_rs, id_use_rt, id_reg_write;
    logic [4:0]       id_rs, id_rt, id_write_reg;
    logic             id_need_buf, buf_ready;
    logic             id_stall, id_issue;
    logic [NREGS-1:0] busy_vec;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cycles, buf_stall_cycles;
`endif

    hazard_scoreboard #(.NUM_REGS(NREGS), .REG_AW(5), .WB_LATENCY(5), .CNT_W(3)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .id_valid     (id_valid),
        .id_kill      (id_kill),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_reg_write (id_reg_write),
        .id_write_reg (id_write_reg),
        .id_need_buf  (id_need_buf),
        .buf_ready    (buf_ready),
        .id_stall     (id_stall),
        .id_issue     (id_issue),
        .busy_vec     (busy_vec)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles     (stall_cycles),
        .buf_stall_cycles (buf_stall_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drv(input string tag, input logic v, input logic k,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw,
                       input logic [4:0] wr, input logic nb, input logic br,
                       input logic es, input logic ei, input logic [31:0] eb);
        exp_t e;
        @(negedge Clk);
        id_valid = v;   id_kill = k;
        id_rs = rs;     id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_write_reg = wr;
        id_need_buf = nb; buf_ready = br;
        e.tag = tag; e.stall = es; e.issue = ei; e.busy = eb;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [31:0] eb);
        drv(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, eb);
    endtask

    // Monitor: compares the head expectation a few ns after each drive point
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_stall"}, 64'(id_stall), 64'(e.stall));
                chk({e.tag, "_issue"}, 64'(id_issue), 64'(e.issue));
                chk({e.tag, "_busy"},  64'(busy_vec), 64'(e.busy[NREGS-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with inputs that would otherwise stall and issue
        Reset = 1'b1;
        id_valid = 1; id_kill = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_reg_write = 1; id_write_reg = 5'd3; id_need_buf = 1; buf_ready = 0;
        #3;
        chk("rst_stall", 64'(id_stall), 64'd0);
        chk("rst_issue", 64'(id_issue), 64'd0);
        chk("rst_busy",  64'(busy_vec), 64'd0);
        @(negedge Clk);
        id_valid = 0; id_reg_write = 0; id_need_buf = 0;
        Reset = 1'b0;

        // 1: ADD $8 then SUB $9,$8,$1 held in ID
        drv("s1_prod", 1, 0, 1, 2, 1, 1, 1, 8, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            drv("s1_stall", 1, 0, 8, 1, 1, 1, 1, 9, 0, 1, 1, 0, 32'd1 << 8);
        drv("s1_issue", 1, 0, 8, 1, 1, 1, 1, 9, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            idle("s1_drain", 32'd1 << 9);
        idle("s1_done", 0);
`ifdef HAZARD_STATS_EN
        chk("s1_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        // 2: write $0 then read $0
        drv("s2_wr0", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
        drv("s2_rd0", 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);

        // 3: WAW reload of $4; non-dependent instruction slips through
        drv("s3_w1",    1, 0, 1, 2, 1, 1, 1, 4, 0, 1, 0, 1, 0);
        drv("s3_indep", 1, 0, 5, 6, 1, 1, 0, 0, 0, 1, 0, 1, 32'd1 << 4);
        drv("s3_w2",    1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 1, 32'd1 << 4);
        for (int i = 0; i < 5; i++)
            drv("s3_stall", 1, 0, 4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 32'd1 << 4);
        drv("s3_issue", 1, 0, 4, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);

        // 4: buffer load waits for buf_ready
        for (int i = 0; i < 3; i++)
            drv("s4_stall", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drv("s4_issue", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);

        // 5: writer of $7 stalled on $3 is killed
        drv("s5_prod", 1, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 1, 0);
        drv("s5_stall", 1, 0, 3, 0, 1, 0, 1, 7, 0, 1, 1, 0, 32'd1 << 3);
        drv("s5_kill",  1, 1, 3, 0, 1, 0, 1, 7, 0, 1, 0, 0, 32'd1 << 3);
        for (int i = 0; i < 3; i++)
            idle("s5_nowr7", 32'd1 << 3);
        idle("s5_done", 0);

        // 6: reset mid-countdown at cnt[5]=3
        drv("s6_prod", 1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 1, 0);
        idle("s6_cnt4", 32'd1 << 5);
        idle("s6_cnt3", 32'd1 << 5);
        @(negedge Clk);
        #4;
        chk("s6_pre_busy", 64'(busy_vec), 64'(32'd1 << 5));
`ifdef HAZARD_STATS_EN
        chk("s6_pre_stall_cycles", 64'(stall_cycles), 64'd14);
        chk("s6_pre_buf_stall", 64'(buf_stall_cycles), 64'd3);
`endif
        #2 Reset = 1'b1;
        #1;
        chk("s6_rst_busy", 64'(busy_vec), 64'd0);
`ifdef HAZARD_STATS_EN
        chk("s6_rst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("s6_rst_buf_stall", 64'(buf_stall_cycles), 64'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        // 7: read and write the same register checks the old counter, then reloads
        drv("s7_rw10",  1, 0, 10, 0, 1, 0, 1, 10, 0, 1, 0, 1, 0);
        drv("s7_again", 1, 0, 10, 0, 1, 0, 1, 10, 0, 1, 1, 0, 32'd1 << 10);
        for (int i = 0; i < 4; i++)
            idle("s7_drain", 32'd1 << 10);
        idle("s7_done", 0);

        // 8: index beyond NUM_REGS is never tracked
        drv("s8_wr30", 1, 0, 0, 0, 0, 0, 1, 30, 0, 1, 0, 1, 0);
        drv("s8_rd30", 1, 0, 30, 30, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        idle("s8_done", 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge Clk);
        #5;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
